led_matrix_scanner: RTL and testbench
=====================================

# led_matrix_scanner

Parametrised, double-buffered LED matrix driver. It receives a complete frame bit-serially over a 3-wire SPI-style link (sck/sdi/load) into a shadow buffer. It commits the frame tear-free to a display buffer at a scan-frame boundary, then time-multiplexes ROWS×COLS pixels across CHANNELS colour planes with per-slot blanking. It sits between the host MCU SPI port and the matrix row/column pins, replacing the fixed 8×8 bicolour scan logic and hard-coded animation tables.

## Interface
- ROWS, 8: rows per matrix; row bus width.
- COLS, 8: columns per colour plane.
- CHANNELS, 2: colour planes (matrices) sharing the row bus.
- SCAN_DIV, 16384: clk cycles per scan slot (one column of one channel); ≥ 4.
- BLANK, 64: cycles at the start of each slot with all columns off; 0 ≤ BLANK < SCAN_DIV.
- FRAME_BITS (derived, localparam): ROWS*COLS*CHANNELS.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- sck  in  1  asynchronous serial clock; data sampled on its rising edge.
- sdi  in  1  asynchronous serial data, first bit first.
- load  in  1  asynchronous frame-enable; high for the whole transfer.
- row  out  ROWS  row drive for the current slot; 1 = LED off.
- col  out  CHANNELS*COLS  one-hot column enable; bit ch*COLS+c = channel ch, column c.
- frame_done  out  1  one-cycle pulse on display-buffer commit.
- err  out  1  one-cycle pulse when a transfer ends with bit count ≠ FRAME_BITS.

## Operation
- sck, sdi, and load each pass through a 2-FF synchroniser. A rising edge of the synchronised sck while synchronised load = 1 shifts synchronised sdi into the shadow buffer.
- The first bit received is channel 0, column 0, row ROWS-1. Rows follow descending. All columns of channel 0 precede channel 1.
- Bit counter: cleared on load rising edge. Increments per shifted bit and saturates at FRAME_BITS+1. Bits beyond FRAME_BITS still shift, so the last FRAME_BITS bits are retained.
- On load falling edge:
  - count == FRAME_BITS: set `pending`.
  - Otherwise: pulse err; shadow is not committed.
- Commit: when `pending` = 1 at the end of the last slot of a scan frame, display ← shadow, pending ← 0, and frame_done pulses in the same cycle the first slot of the new frame begins.
- A load rising edge while pending = 1 cancels pending. The new transfer overwrites the shadow buffer, and no frame_done is issued for the cancelled frame.
- Scan: slot index s = 0 … COLS*CHANNELS-1. Channel = s / COLS, column = s mod COLS. Slots are column-major within a channel, and channel 0 comes first. The index wraps from the last slot to 0.
- In each slot:
  - row = display bits for (channel, column), row r on row[r].
  - col = one-hot for that slot, but all zeros while the slot cycle counter < BLANK.
- Reset values:
  - row all ones; col all zeros.
  - frame_done = 0, err = 0, pending = 0.
  - Display and shadow buffers all ones (blank).
  - Slot index 0, slot cycle counter 0, bit counter 0.

## Timing
- sck high and low phases must each be ≥ 3 clk periods. load setup to the first sck rise ≥ 3 clk. load hold after the last sck rise ≥ 3 clk.
- Input-to-shift latency: 3 clk after sck rises at the pin (2 synchroniser + 1 edge register).
- Slot cycle counter runs 0 … SCAN_DIV-1. The slot advances on wrap.
- row/col are registered and update on the first clk of each slot.
- With BLANK = 0, col is never all-zero within a slot; with BLANK > 0, col goes high at slot cycle BLANK.
- A scan frame is COLS*CHANNELS*SCAN_DIV cycles. Worst-case commit latency after a valid load fall is 1 scan frame + 4 clk.
- Simultaneous load fall and scan-frame end: pending is set first; commit happens at the next frame end.
- Reset mid-transfer or mid-scan: all state returns to reset values on the next clk edge. A partial frame is discarded with no err.

## Structure
- Package led_matrix_pkg holds:
  - the default ROWS/COLS/CHANNELS/SCAN_DIV/BLANK constants;
  - function slot_onehot(s) returning the col vector;
  - the frame bit-index function idx(ch, c, r).
- Sub-module spi_frame_rx contains the synchronisers, edge detection, shadow shift register, bit counter, pending/err generation, and the cancel rule. It outputs the shadow buffer, pending, and err.
- The top level contains the slot/cycle counters, commit logic, display buffer, and output registers.

## Test plan
- Default params: send 128 bits with ch0 col0 = 8'h7E, everything else 1s. Required:
  - err never pulses.
  - frame_done pulses once at the next frame boundary.
  - In slot 0: row = 8'h7E and col = 16'h0001 after BLANK cycles, col = 0 during blanking.
- Send 127 bits then drop load → err pulses once; no frame_done; display stays all ones.
- Send 130 bits → err pulses; display unchanged.
- Set ROWS=4, COLS=5, CHANNELS=3, SCAN_DIV=8, BLANK=2. Observe the col one-hot sequence bit 0…14, then wrap to 0. Each bit is high for exactly 6 cycles per 8-cycle slot.
- Cancel rule: send valid frame A, then start frame B before the frame boundary and complete it validly. Required: exactly one frame_done, and the display shows B.
- Assert reset mid-transfer at bit 50 → row = all ones and col = 0 the next cycle. A following full 128-bit frame commits correctly.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared constants and helpers for the LED matrix scanner: default geometry,
// slot-to-column one-hot decode and frame bit ordering.
package led_matrix_pkg;

  localparam int unsigned ROWS_DEF     = 8;
  localparam int unsigned COLS_DEF     = 8;
  localparam int unsigned CHANNELS_DEF = 2;
  localparam int unsigned SCAN_DIV_DEF = 16384;
  localparam int unsigned BLANK_DEF    = 64;

  // Widest column bus the one-hot helper can serve (COLS*CHANNELS).
  localparam int unsigned MAX_SLOTS = 64;

  function automatic logic [MAX_SLOTS-1:0] slot_onehot(input int unsigned s);
    return MAX_SLOTS'(1) << s;
  endfunction

  // Shadow position of pixel (ch, c, r); bits arrive ch0 col0 row ROWS-1 first.
  function automatic int unsigned idx(input int unsigned ch, input int unsigned c,
                                      input int unsigned r, input int unsigned rows,
                                      input int unsigned cols);
    return ch * cols * rows + c * rows + (rows - 1 - r);
  endfunction

endpackage

// File: rtl/led_matrix_scanner_spi_frame_rx.sv
// Serial frame receiver: synchronises sck/sdi/load, shifts bits into the
// shadow buffer and flags complete (pending) or malformed (err) transfers.
module spi_frame_rx
  import led_matrix_pkg::*;
#(
  parameter int unsigned FRAME_BITS = ROWS_DEF * COLS_DEF * CHANNELS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_sck,
  input  logic                  i_sdi,
  input  logic                  i_load,
  input  logic                  i_commit,
  output logic [FRAME_BITS-1:0] o_shadow,
  output logic                  o_pending,
  output logic                  o_err
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);

  logic [1:0]       r_sck_sync;
  logic [1:0]       r_sdi_sync;
  logic [1:0]       r_load_sync;
  logic             r_sck_prev;
  logic             r_load_prev;
  logic [CNT_W-1:0] r_cnt;

  logic w_sck_rise;
  logic w_load_rise;
  logic w_load_fall;
  logic w_shift;
  logic w_cnt_full;

  assign w_sck_rise  = r_sck_sync[1] & ~r_sck_prev;
  assign w_load_rise = r_load_sync[1] & ~r_load_prev;
  assign w_load_fall = ~r_load_sync[1] & r_load_prev;
  assign w_shift     = w_sck_rise & r_load_sync[1];
  assign w_cnt_full  = (r_cnt == CNT_W'(FRAME_BITS));

  // Shift right so the first bit of a frame ends up at position 0.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sck_sync  <= '0;
      r_sdi_sync  <= '0;
      r_load_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_load_prev <= 1'b0;
      r_cnt       <= '0;
      o_shadow    <= '1;
      o_pending   <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[0], i_sck};
      r_sdi_sync  <= {r_sdi_sync[0], i_sdi};
      r_load_sync <= {r_load_sync[0], i_load};
      r_sck_prev  <= r_sck_sync[1];
      r_load_prev <= r_load_sync[1];
      o_err       <= w_load_fall & ~w_cnt_full;

      if (w_shift) begin
        o_shadow <= {r_sdi_sync[1], o_shadow[FRAME_BITS-1:1]};
      end

      if (w_load_rise) begin
        r_cnt <= '0;
      end else if (w_shift && (r_cnt != CNT_W'(FRAME_BITS + 1))) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // A new transfer starting cancels any frame still waiting for commit.
      if (w_load_fall && w_cnt_full) begin
        o_pending <= 1'b1;
      end else if (w_load_rise || i_commit) begin
        o_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered LED matrix driver: commits received frames at scan-frame
// boundaries and multiplexes one column of one channel per slot with blanking.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROWS     = ROWS_DEF,
  parameter int unsigned COLS     = COLS_DEF,
  parameter int unsigned CHANNELS = CHANNELS_DEF,
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEF,
  parameter int unsigned BLANK    = BLANK_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sck,
  input  logic                       sdi,
  input  logic                       load,
  output logic [ROWS-1:0]            row,
  output logic [CHANNELS*COLS-1:0]   col,
  output logic                       frame_done,
  output logic                       err
);

  localparam int unsigned NSLOT      = COLS * CHANNELS;
  localparam int unsigned FRAME_BITS = ROWS * COLS * CHANNELS;
  localparam int unsigned SLOT_W     = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int unsigned CYC_W      = $clog2(SCAN_DIV);

  logic [CYC_W-1:0]      r_cyc;
  logic [SLOT_W-1:0]     r_slot;
  logic [FRAME_BITS-1:0] r_disp;

  logic [FRAME_BITS-1:0] w_shadow;
  logic                  w_pending;
  logic                  w_cyc_wrap;
  logic                  w_frame_end;
  logic                  w_commit;
  logic                  w_blank;
  logic [CYC_W-1:0]      w_cyc_next;
  logic [SLOT_W-1:0]     w_slot_next;
  logic [FRAME_BITS-1:0] w_disp_next;
  logic [NSLOT-1:0]      w_col_next;
  logic [ROWS-1:0]       w_slot_rows [NSLOT];

  spi_frame_rx #(
    .FRAME_BITS(FRAME_BITS)
  ) u_rx (
    .i_clk     (clk),
    .i_reset_n (reset),
    .i_sck     (sck),
    .i_sdi     (sdi),
    .i_load    (load),
    .i_commit  (w_commit),
    .o_shadow  (w_shadow),
    .o_pending (w_pending),
    .o_err     (err)
  );

  assign w_cyc_wrap  = (r_cyc == CYC_W'(SCAN_DIV - 1));
  assign w_frame_end = w_cyc_wrap && (r_slot == SLOT_W'(NSLOT - 1));
  assign w_commit    = w_frame_end && w_pending;
  assign w_disp_next = w_commit ? w_shadow : r_disp;
  assign w_blank     = (32'(w_cyc_next) < BLANK);
  assign w_col_next  = NSLOT'(slot_onehot(32'(w_slot_next)));

  // Slot/cycle counters; the slot only advances when the cycle counter wraps.
  always_comb begin
    w_cyc_next  = r_cyc + CYC_W'(1);
    w_slot_next = r_slot;
    if (w_cyc_wrap) begin
      w_cyc_next  = '0;
      w_slot_next = w_frame_end ? '0 : r_slot + SLOT_W'(1);
    end
  end

  // Fixed mapping from each slot to its row bits in the display buffer.
  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign w_slot_rows[s][r] = w_disp_next[idx(s / COLS, s % COLS, r, ROWS, COLS)];
    end
  end

  // Outputs are computed from next-state so they change on the slot's first clk.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cyc      <= '0;
      r_slot     <= '0;
      r_disp     <= '1;
      row        <= '1;
      col        <= '0;
      frame_done <= 1'b0;
    end else begin
      r_cyc      <= w_cyc_next;
      r_slot     <= w_slot_next;
      r_disp     <= w_disp_next;
      row        <= w_slot_rows[w_slot_next];
      col        <= w_blank ? '0 : w_col_next;
      frame_done <= w_commit;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: a pin-level transaction model predicts row/col/
// frame_done/err every cycle, plus hand-computed literal pins on key cycles.
module tb_led_matrix_scanner;

  localparam int R = 8, C = 8, CH = 2, SD = 256, BL = 16;
  localparam int FB = R * C * CH, NS = C * CH, F = NS * SD;
  localparam int R2 = 4, C2 = 5, CH2 = 3, SD2 = 8, BL2 = 2;
  localparam int NS2 = C2 * CH2, F2 = NS2 * SD2;

  logic clk = 1'b0, reset = 1'b0, sck = 1'b0, sdi = 1'b0, load = 1'b0;
  logic [R-1:0]   row;
  logic [NS-1:0]  col;
  logic           frame_done, err;
  logic [R2-1:0]  row2;
  logic [NS2-1:0] col2;
  logic           fd2, err2;

  led_matrix_scanner #(.ROWS(R), .COLS(C), .CHANNELS(CH), .SCAN_DIV(SD), .BLANK(BL)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .load(load),
    .row(row), .col(col), .frame_done(frame_done), .err(err)
  );

  led_matrix_scanner #(.ROWS(R2), .COLS(C2), .CHANNELS(CH2), .SCAN_DIV(SD2), .BLANK(BL2)) dut2 (
    .clk(clk), .reset(reset), .sck(1'b0), .sdi(1'b0), .load(1'b0),
    .row(row2), .col(col2), .frame_done(fd2), .err(err2)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int t = 0, err_due = -1, nbits = 0, n_fd = 0, n_err = 0;
  int cnt_req = 0, cnt_done = 0, exp_nfd = 0, exp_nerr = 0;
  int hi2 [NS2];
  bit disp [FB];
  bit pend [FB];
  bit q [$];
  bit pending_m = 0, load_q = 0, sck_q = 0, lit_en = 0, tmo = 0, tmo_seen = 0;
  logic [7:0] lit_row = 8'hFF;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h want=%h", nm, t, got, exp);
    end
  endtask

  function automatic logic pat(input int mode, input int k);
    logic [7:0] a;
    a = 8'h7E;
    case (mode)
      0:       return (k < 8) ? a[7-k] : 1'b1;
      1:       return (k % 5) != 0;
      2:       return (k % 3) != 0;
      default: return 1'b1;
    endcase
  endfunction

  // Model update on each edge, then compare 1 time unit later.
  always @(posedge clk) begin : cmp
    logic [R-1:0]   er;
    logic [NS-1:0]  ec;
    logic [NS2-1:0] ec2;
    logic           efd;
    int             s;
    efd = 1'b0;
    if (!reset) begin
      t = 0; err_due = -1; pending_m = 0; nbits = 0;
      q.delete();
      foreach (disp[i]) disp[i] = 1'b1;
      foreach (hi2[i]) hi2[i] = 0;
    end else begin
      t++;
      if (load && !load_q) begin
        pending_m = 0; nbits = 0; q.delete();
      end
      if (sck && !sck_q && load) begin
        q.push_back(sdi);
        if (q.size() > FB) void'(q.pop_front());
        nbits++;
      end
      if (!load && load_q) begin
        if (nbits == FB) begin
          foreach (pend[i]) pend[i] = q[i];
          pending_m = 1;
        end else begin
          err_due = t + 2;
        end
      end
      if ((t % F) == 0 && pending_m) begin
        disp = pend; pending_m = 0; efd = 1'b1;
      end
    end
    load_q = load;
    sck_q  = sck;
    #1;
    s  = (t / SD) % NS;
    ec = '0;
    if ((t % SD) >= BL) ec[s] = 1'b1;
    for (int r = 0; r < R; r++) er[r] = disp[(s / C) * C * R + (s % C) * R + R - 1 - r];
    checks++;
    if (row !== er || col !== ec || frame_done !== efd || err !== (t == err_due)) begin
      failures++;
      $display("FAIL scan t=%0d row=%h want=%h col=%h want=%h fd=%b want=%b err=%b want=%b",
               t, row, er, col, ec, frame_done, efd, err, (t == err_due));
    end
    if (frame_done === 1'b1) n_fd++;
    if (err === 1'b1) n_err++;

    ec2 = '0;
    if ((t % SD2) >= BL2) ec2[(t / SD2) % NS2] = 1'b1;
    checks++;
    if (col2 !== ec2 || row2 !== 4'hF || fd2 !== 1'b0 || err2 !== 1'b0) begin
      failures++;
      $display("FAIL small t=%0d col2=%h want=%h row2=%h fd2=%b err2=%b", t, col2, ec2, row2, fd2, err2);
    end
    if (t < F2) for (int b = 0; b < NS2; b++) hi2[b] += int'(col2[b]);
    if (t == F2) for (int b = 0; b < NS2; b++) chk("col2_high_cycles", 32'(hi2[b]), 32'd6);
    if (t == 114) chk("col2_slot14", 32'(col2), 32'h4000);
    if (t == 121) chk("col2_wrap_blank", 32'(col2), 32'h0);
    if (t == 122) chk("col2_wrap_slot0", 32'(col2), 32'h0001);

    if (!reset) begin
      chk("reset_row", 32'(row), 32'hFF);
      chk("reset_col", 32'(col), 32'h0);
    end
    if (lit_en && reset) begin
      if ((t % F) == 3) begin
        chk("slot0_blank_col", 32'(col), 32'h0);
        chk("slot0_blank_row", 32'(row), 32'(lit_row));
      end
      if ((t % F) == BL + 1) begin
        chk("slot0_col", 32'(col), 32'h0001);
        chk("slot0_row", 32'(row), 32'(lit_row));
      end
      if ((t % F) == SD + BL + 1) chk("slot1_col", 32'(col), 32'h0002);
    end
    if (cnt_req != cnt_done) begin
      chk("frame_done_count", 32'(n_fd), 32'(exp_nfd));
      chk("err_count", 32'(n_err), 32'(exp_nerr));
      cnt_done = cnt_req;
    end
    if (tmo && !tmo_seen) begin
      tmo_seen = 1;
      checks++;
      failures++;
      $display("FAIL wait_bound t=%0d expired", t);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Keep load edges clear of the scan-frame boundary so commit timing is unambiguous.
  task automatic wait_safe();
    int k = 0;
    while ((t % F) >= F - 8 && k < 64) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_phase(input int p);
    int k = 0;
    while ((t % F) != p && k < 2 * F) begin
      @(negedge clk);
      k++;
    end
    if ((t % F) != p) tmo = 1;
  endtask

  task automatic wait_fd(input int prev);
    int k = 0;
    while (n_fd <= prev && k < 2 * F + 64) begin
      @(negedge clk);
      k++;
    end
    if (n_fd <= prev) tmo = 1;
  endtask

  task automatic req(input int nfd, input int nerr);
    exp_nfd  = nfd;
    exp_nerr = nerr;
    cnt_req++;
    tick(2);
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    tick(4);
    sck = 1'b1;
    tick(4);
    sck = 1'b0;
  endtask

  task automatic xfer(input int n, input int mode);
    wait_safe();
    load = 1'b1;
    tick(4);
    for (int k = 0; k < n; k++) send_bit(pat(mode, k));
    tick(4);
    wait_safe();
    load = 1'b0;
    tick(6);
  endtask

  initial begin
    tick(4);
    reset = 1'b1;
    tick(4);

    // Valid frame: ch0 col0 = 8'h7E.
    xfer(FB, 0);
    wait_fd(0);
    lit_row = 8'h7E;
    lit_en  = 1;
    tick(SD + BL + 8);
    req(1, 0);

    // Short and long transfers must be rejected.
    xfer(FB - 1, 1);
    tick(F + 16);
    req(1, 1);
    xfer(FB + 2, 1);
    tick(F + 16);
    req(1, 2);

    // Frame B cancelled by frame C before the boundary.
    lit_en = 0;
    wait_phase(8);
    xfer(FB, 1);
    xfer(FB, 2);
    wait_fd(1);
    lit_row = 8'h6D;
    lit_en  = 1;
    tick(F + 16);
    req(2, 2);

    // Reset in the middle of a transfer, then a clean frame.
    lit_en = 0;
    load   = 1'b1;
    tick(4);
    for (int k = 0; k < 50; k++) send_bit(pat(2, k));
    reset = 1'b0;
    load  = 1'b0;
    sck   = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(4);
    xfer(FB, 0);
    wait_fd(2);
    lit_row = 8'h7E;
    lit_en  = 1;
    tick(SD + BL + 8);
    req(3, 2);

    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "watchdog expired");
  end

endmodule
